tmp_dig_seq: RTL and testbench
==============================

TMP_DIG_SEQ -- requirements
Module: tmp_dig_seq

Interface
REQ-001 Parameter NCH, default 4: number of sensor channels; legal range 1..8.
REQ-002 Parameter NCYC, default 16: diode/big-diode decision cycles per conversion; legal range 2..255.
REQ-003 Parameter PRE_CYC, default 15: precharge length in clk cycles; minimum 1.
REQ-004 Parameter DIODE_CYC, default 8: DIODE phase length in cycles; minimum 3.
REQ-005 Parameter BIG_CYC, default 8: BIGDIODE phase length in cycles; minimum 3.
REQ-006 Ports, in order:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock, reset synchronous and active-low.
- start  in  1  conversion request.
- ch_mask  in  NCH  enabled channels.
- cmp  in  1  comparator output.
- PI1, PI2, PII1, PII2  out  1 each  switch phases.
- preChrg, setupBias  out  1 each  precharge and bias enable.
- cmp_p1, cmp_p2  out  1 each  comparator chopping phases.
- src_n, snk  out  1 each  feedback current control.
- ch_sel  out  NCH  one-hot active channel.
- busy  out  1  conversion sequence in progress.
- valid  out  1  result strobe.
- result  out  clog2(NCYC+1)  result count.
- result_ch  out  max(1,clog2(NCH))  result channel index.

Function
REQ-007 FSM states: IDLE, PRECHG, BLANK_D, DIODE, BLANK_B, BIGDIODE, OUTPUT.
REQ-008 In IDLE, start=1 with ch_mask!=0 SHALL latch ch_mask, set busy=1 on the next edge and enter PRECHG; start with ch_mask=0 SHALL be ignored; start while busy SHALL be ignored.
REQ-009 PRECHG SHALL last exactly PRE_CYC cycles:
- preChrg=1 during PRECHG.
- setupBias is set to 1 on first PRECHG entry and held 1 until reset.
- Exit is to BLANK_D with ch_sel set to the lowest enabled channel, decision counter k=0 and result accumulator acc=0.
REQ-010 BLANK_D and BLANK_B SHALL last exactly 1 cycle with PI1=PI2=PII1=PII2=0 (non-overlap gap).
REQ-011 DIODE SHALL last DIODE_CYC cycles:
- PII1=1 in all DIODE cycles.
- PII2=1 in cycles 2..DIODE_CYC-1 only.
- cmp_p1/cmp_p2 SHALL invert on DIODE exit and remain complementary at all times.
REQ-012 BIGDIODE SHALL last BIG_CYC cycles:
- PI1=1 in all BIGDIODE cycles.
- PI2=1 in cycles 2..BIG_CYC-1 only.
- cmp is sampled on the last cycle.
REQ-013 On each BIGDIODE sample:
- cmp=1: src_n=1, snk=0, acc increments.
- cmp=0: src_n=0, snk=1, acc unchanged.
- Both updates take effect on the following edge, and src_n/snk are held until the next sample.
- k increments.
REQ-014 After a sample with k<NCYC-1 (pre-increment value): go to BLANK_D. After the NCYC-th sample: go to OUTPUT.
REQ-015 acc width is clog2(NCYC+1); acc never exceeds NCYC and SHALL NOT wrap.
REQ-016 OUTPUT SHALL last 1 cycle:
- valid=1, result=acc, result_ch=index of the active channel.
- src_n=snk=0.
- Then go to BLANK_D for the next enabled channel in ascending order, or to IDLE when none remain.
REQ-017 Disabled channels SHALL be skipped with zero cycles spent; ch_sel SHALL be all-zero in IDLE and PRECHG.
REQ-018 Total latency per enabled channel SHALL be NCYC*(DIODE_CYC+BIG_CYC+2)+1 cycles; busy SHALL drop on the edge that enters IDLE.
REQ-019 result/result_ch SHALL hold the last value between valid pulses; valid is a single-cycle pulse per channel.
REQ-020 Changes of ch_mask while busy SHALL have no effect until the next start.

Reset
REQ-021 reset_n=0 at a clk edge SHALL force IDLE, including mid-conversion, with no valid pulse for the aborted channel. Resulting values:
- All phase outputs, preChrg, setupBias, src_n, snk, busy, valid = 0.
- cmp_p1=1, cmp_p2=0.
- ch_sel=0, result=0, result_ch=0, acc=0, k=0.
REQ-022 No initial blocks are relied on; every register SHALL have a defined reset value.

Verification
REQ-023 Defaults, ch_mask=4'b0001, cmp held 1 -> one valid pulse, result=16, result_ch=0, 16*18+1 cycles after PRECHG exit.
REQ-024 ch_mask=4'b1010, cmp alternating per sample starting 0 -> valid for ch 1 then ch 3, result=8 each, ch_sel one-hot 0010 then 1000.
REQ-025 Phase check over a full conversion -> PI1&PII1 never 1 together, PI2 only while PI1=1, PII2 only while PII1=1, cmp_p1 != cmp_p2 in every cycle.
REQ-026 reset_n=0 for 1 cycle mid-BIGDIODE of ch 0 -> IDLE with all reset values next cycle, no valid; new start runs a full conversion normally.
REQ-027 start with ch_mask=0, and start pulsed while busy -> no state change in either case; NCYC=2, cmp=0 -> result=0.

Source files
------------

// File: rtl/tmp_dig_seq.sv
// Temperature-sensor digital sequencer: precharge, diode / big-diode switching phases,
// comparator-driven current feedback and per-channel result accumulation.
//
// state      | meaning
// IDLE       | waiting for start with a non-empty channel mask
// PRECHG     | precharge, PRE_CYC cycles, bias enabled
// BLANK_D    | one-cycle non-overlap gap before DIODE
// DIODE      | PII1 phase, PII2 inside the non-overlap window
// BLANK_B    | one-cycle non-overlap gap before BIGDIODE
// BIGDIODE   | PI1 phase, PI2 inside the window, comparator sampled on last cycle
// OUTPUT     | one-cycle result strobe, then next channel or IDLE
module tmp_dig_seq #(
   parameter int NCH       = 4,
   parameter int NCYC      = 16,
   parameter int PRE_CYC   = 15,
   parameter int DIODE_CYC = 8,
   parameter int BIG_CYC   = 8,
   localparam int RW = $clog2(NCYC + 1),
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [NCH-1:0] ch_mask,
   input  logic           cmp,
   output logic           PI1,
   output logic           PI2,
   output logic           PII1,
   output logic           PII2,
   output logic           preChrg,
   output logic           setupBias,
   output logic           cmp_p1,
   output logic           cmp_p2,
   output logic           src_n,
   output logic           snk,
   output logic [NCH-1:0] ch_sel,
   output logic           busy,
   output logic           valid,
   output logic [RW-1:0]  result,
   output logic [IW-1:0]  result_ch
);

   localparam int MAXC = (PRE_CYC > DIODE_CYC) ?
                         ((PRE_CYC > BIG_CYC) ? PRE_CYC : BIG_CYC) :
                         ((DIODE_CYC > BIG_CYC) ? DIODE_CYC : BIG_CYC);
   localparam int PW = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRECHG, S_BLANK_D, S_DIODE, S_BLANK_B, S_BIGDIODE, S_OUTPUT
   } state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  cnt_q, cnt_d;
   logic [RW-1:0]  k_q, k_d, acc_q, acc_d, result_q, result_d;
   logic [NCH-1:0] mask_q, mask_d, ch_sel_q, ch_sel_d;
   logic [IW-1:0]  ch_idx_q, ch_idx_d, result_ch_q, result_ch_d;
   logic           pi1_q, pi1_d, pi2_q, pi2_d, pii1_q, pii1_d, pii2_q, pii2_d;
   logic           pre_chrg_q, pre_chrg_d, setup_bias_q, setup_bias_d;
   logic           cmp_p1_q, cmp_p1_d, cmp_p2_q, cmp_p2_d;
   logic           src_n_q, src_n_d, snk_q, snk_d;
   logic           busy_q, busy_d, valid_q, valid_d;
   logic           nxt_found;
   logic [IW-1:0]  nxt_idx;

   always_comb begin
      // Lowest enabled channel above the active one; from PRECHG any enabled channel qualifies.
      nxt_found = 1'b0;
      nxt_idx   = '0;
      for (int j = NCH - 1; j >= 0; j--) begin
         if (mask_q[j] && (state_q == S_PRECHG || j > int'(ch_idx_q))) begin
            nxt_found = 1'b1;
            nxt_idx   = IW'(j);
         end
      end

      state_d      = state_q;
      cnt_d        = cnt_q;
      k_d          = k_q;
      acc_d        = acc_q;
      mask_d       = mask_q;
      ch_idx_d     = ch_idx_q;
      ch_sel_d     = ch_sel_q;
      setup_bias_d = setup_bias_q;
      cmp_p1_d     = cmp_p1_q;
      cmp_p2_d     = cmp_p2_q;
      src_n_d      = src_n_q;
      snk_d        = snk_q;
      result_d     = result_q;
      result_ch_d  = result_ch_q;
      valid_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && (|ch_mask)) begin
               mask_d  = ch_mask;
               state_d = S_PRECHG;
               cnt_d   = PW'(1);
            end
         end
         S_PRECHG: begin
            if (cnt_q == PW'(PRE_CYC)) begin
               state_d  = S_BLANK_D;
               ch_idx_d = nxt_idx;
               ch_sel_d = NCH'(1) << nxt_idx;
               k_d      = '0;
               acc_d    = '0;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         S_BLANK_D: begin
            state_d = S_DIODE;
            cnt_d   = PW'(1);
         end
         S_DIODE: begin
            if (cnt_q == PW'(DIODE_CYC)) state_d = S_BLANK_B;
            else                         cnt_d   = cnt_q + PW'(1);
         end
         S_BLANK_B: begin
            state_d = S_BIGDIODE;
            cnt_d   = PW'(1);
         end
         S_BIGDIODE: begin
            if (cnt_q == PW'(BIG_CYC)) begin
               k_d     = k_q + RW'(1);
               src_n_d = cmp;
               snk_d   = ~cmp;
               if (cmp && acc_q < RW'(NCYC)) acc_d = acc_q + RW'(1);
               state_d = (k_q == RW'(NCYC - 1)) ? S_OUTPUT : S_BLANK_D;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         S_OUTPUT: begin
            if (nxt_found) begin
               state_d  = S_BLANK_D;
               ch_idx_d = nxt_idx;
               ch_sel_d = NCH'(1) << nxt_idx;
               k_d      = '0;
               acc_d    = '0;
            end else begin
               state_d  = S_IDLE;
               ch_sel_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Registered outputs are decoded from the state being entered.
      pre_chrg_d = (state_d == S_PRECHG);
      if (state_d == S_PRECHG) setup_bias_d = 1'b1;
      pii1_d = (state_d == S_DIODE);
      pii2_d = (state_d == S_DIODE) && (cnt_d >= PW'(2)) && (cnt_d <= PW'(DIODE_CYC - 1));
      pi1_d  = (state_d == S_BIGDIODE);
      pi2_d  = (state_d == S_BIGDIODE) && (cnt_d >= PW'(2)) && (cnt_d <= PW'(BIG_CYC - 1));
      if (state_q == S_DIODE && state_d != S_DIODE) begin
         cmp_p1_d = ~cmp_p1_q;
         cmp_p2_d = cmp_p1_q;
      end
      busy_d = (state_d != S_IDLE);
      if (state_d == S_OUTPUT) begin
         valid_d     = 1'b1;
         result_d    = acc_d;
         result_ch_d = ch_idx_d;
         src_n_d     = 1'b0;
         snk_d       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         k_q          <= '0;
         acc_q        <= '0;
         mask_q       <= '0;
         ch_idx_q     <= '0;
         ch_sel_q     <= '0;
         pi1_q        <= 1'b0;
         pi2_q        <= 1'b0;
         pii1_q       <= 1'b0;
         pii2_q       <= 1'b0;
         pre_chrg_q   <= 1'b0;
         setup_bias_q <= 1'b0;
         cmp_p1_q     <= 1'b1;
         cmp_p2_q     <= 1'b0;
         src_n_q      <= 1'b0;
         snk_q        <= 1'b0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         result_q     <= '0;
         result_ch_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         acc_q        <= acc_d;
         mask_q       <= mask_d;
         ch_idx_q     <= ch_idx_d;
         ch_sel_q     <= ch_sel_d;
         pi1_q        <= pi1_d;
         pi2_q        <= pi2_d;
         pii1_q       <= pii1_d;
         pii2_q       <= pii2_d;
         pre_chrg_q   <= pre_chrg_d;
         setup_bias_q <= setup_bias_d;
         cmp_p1_q     <= cmp_p1_d;
         cmp_p2_q     <= cmp_p2_d;
         src_n_q      <= src_n_d;
         snk_q        <= snk_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         result_q     <= result_d;
         result_ch_q  <= result_ch_d;
      end
   end

   assign PI1       = pi1_q;
   assign PI2       = pi2_q;
   assign PII1      = pii1_q;
   assign PII2      = pii2_q;
   assign preChrg   = pre_chrg_q;
   assign setupBias = setup_bias_q;
   assign cmp_p1    = cmp_p1_q;
   assign cmp_p2    = cmp_p2_q;
   assign src_n     = src_n_q;
   assign snk       = snk_q;
   assign ch_sel    = ch_sel_q;
   assign busy      = busy_q;
   assign valid     = valid_q;
   assign result    = result_q;
   assign result_ch = result_ch_q;

endmodule

// File: tb/tb_tmp_dig_seq.sv
// Directed bench for tmp_dig_seq: default instance for multi-channel runs and reset abort,
// small NCYC=2 instance for the zero / full-scale result boundaries.
module tb_tmp_dig_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, start, cmp;
   logic [3:0] ch_mask;
   logic       PI1, PI2, PII1, PII2, preChrg, setupBias, cmp_p1, cmp_p2, src_n, snk;
   logic [3:0] ch_sel;
   logic       busy, valid;
   logic [4:0] result;
   logic [1:0] result_ch;

   logic       start2, cmp2;
   logic [3:0] mask2;
   logic       PI1_2, PI2_2, PII1_2, PII2_2, pre2, bias2, cp1_2, cp2_2, src2, snk2;
   logic [3:0] sel2;
   logic       busy2, valid2;
   logic [1:0] result2;
   logic [1:0] rch2;

   tmp_dig_seq u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ch_mask(ch_mask), .cmp(cmp),
      .PI1(PI1), .PI2(PI2), .PII1(PII1), .PII2(PII2), .preChrg(preChrg),
      .setupBias(setupBias), .cmp_p1(cmp_p1), .cmp_p2(cmp_p2), .src_n(src_n),
      .snk(snk), .ch_sel(ch_sel), .busy(busy), .valid(valid), .result(result),
      .result_ch(result_ch)
   );

   tmp_dig_seq #(.NCYC(2), .PRE_CYC(1), .DIODE_CYC(3), .BIG_CYC(3)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .start(start2), .ch_mask(mask2), .cmp(cmp2),
      .PI1(PI1_2), .PI2(PI2_2), .PII1(PII1_2), .PII2(PII2_2), .preChrg(pre2),
      .setupBias(bias2), .cmp_p1(cp1_2), .cmp_p2(cp2_2), .src_n(src2),
      .snk(snk2), .ch_sel(sel2), .busy(busy2), .valid(valid2), .result(result2),
      .result_ch(rch2)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Monitor runs 2 time units after each rising edge; main sequence acts on falling edges.
   logic alt_mode = 1'b0, alt_val = 1'b0, cmp_const = 1'b0, mon_en = 1'b0;
   logic pi1_prev = 1'b0, pre_prev = 1'b0, valid_prev = 1'b0;
   int   cyc = 0, viol = 0, n_samp = 0, pre_exit_cyc = 0, n_valid = 0;
   int   v_res[$], v_ch[$], v_sel[$], v_cyc[$], v_drv[$];

   assign cmp = alt_mode ? alt_val : cmp_const;

   always @(posedge clk) begin
      #2;
      cyc++;
      if (mon_en) begin
         if ((PI1 && PII1) || (PI2 && !PI1) || (PII2 && !PII1) || (cmp_p1 === cmp_p2)) viol++;
         if ((PI1_2 && PII1_2) || (PI2_2 && !PI1_2) || (PII2_2 && !PII1_2) || (cp1_2 === cp2_2)) viol++;
         if (valid && valid_prev) viol++;
         if (pre_prev && !preChrg) pre_exit_cyc = cyc;
         if (pi1_prev && !PI1) begin
            n_samp++;
            if (alt_mode) alt_val = ~alt_val;
         end
         if (!alt_mode) alt_val = 1'b0;
         if (valid) begin
            n_valid++;
            v_res.push_back(int'(result));
            v_ch.push_back(int'(result_ch));
            v_sel.push_back(int'(ch_sel));
            v_cyc.push_back(cyc);
            v_drv.push_back(int'({src_n, snk}));
         end
      end
      pi1_prev   = PI1;
      pre_prev   = preChrg;
      valid_prev = valid;
   end

   task automatic wait_valid(input int n, input int budget);
      int t = 0;
      while (n_valid < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("valid_arrival", 32'(n_valid >= n), 32'd1);
   endtask

   initial begin
      int s0, t;
      reset_n = 1'b0; start = 1'b0; ch_mask = '0; start2 = 1'b0; mask2 = '0; cmp2 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_bias", 32'(setupBias), 32'd0);
      check("rst_cmp_p", 32'({cmp_p1, cmp_p2}), 32'b10);
      check("rst_phases", 32'({PI1, PI2, PII1, PII2, preChrg, src_n, snk}), 32'd0);
      check("rst_ch_sel", 32'(ch_sel), 32'd0);
      check("rst_result", 32'({result, result_ch}), 32'd0);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // Single channel, comparator always 1: full-scale result.
      ch_mask = 4'b0001; cmp_const = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("r1_busy", 32'(busy), 32'd1);
      check("r1_prechg", 32'(preChrg), 32'd1);
      check("r1_bias", 32'(setupBias), 32'd1);
      check("r1_sel_prechg", 32'(ch_sel), 32'd0);
      t = 0;
      while (n_samp < 1 && t < 100) begin @(negedge clk); t++; end
      check("r1_src_snk", 32'({src_n, snk}), 32'b10);
      wait_valid(1, 1000);
      check("r1_result", 32'(v_res[0]), 32'd16);
      check("r1_result_ch", 32'(v_ch[0]), 32'd0);
      check("r1_sel", 32'(v_sel[0]), 32'b0001);
      check("r1_out_drv", 32'(v_drv[0]), 32'd0);
      // valid lands in the 289th cycle counting the first BLANK_D cycle as 1
      check("r1_latency", 32'(v_cyc[0] - pre_exit_cyc), 32'd288);
      @(negedge clk);
      check("r1_busy_drop", 32'(busy), 32'd0);
      check("r1_hold", 32'({valid, result}), 32'd16);

      // Channels 1 and 3, comparator alternating 0,1,... per sample; mask change and start ignored.
      ch_mask = 4'b1010; alt_mode = 1'b1; start = 1'b1; s0 = n_samp;
      @(negedge clk);
      start = 1'b0; ch_mask = 4'b0001;
      t = 0;
      while (ch_sel == 4'd0 && t < 100) begin @(negedge clk); t++; end
      check("r2_first_sel", 32'(ch_sel), 32'b0010);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("r2_busy_start", 32'({busy, preChrg, ch_sel}), 32'b1_0_0010);
      t = 0;
      while (n_samp < s0 + 1 && t < 100) begin @(negedge clk); t++; end
      check("r2_src_snk", 32'({src_n, snk}), 32'b01);
      wait_valid(3, 2000);
      check("r2_res_a", 32'(v_res[1]), 32'd8);
      check("r2_ch_a", 32'(v_ch[1]), 32'd1);
      check("r2_sel_a", 32'(v_sel[1]), 32'b0010);
      check("r2_res_b", 32'(v_res[2]), 32'd8);
      check("r2_ch_b", 32'(v_ch[2]), 32'd3);
      check("r2_sel_b", 32'(v_sel[2]), 32'b1000);
      check("r2_skip_gap", 32'(v_cyc[2] - v_cyc[1]), 32'd289);
      @(negedge clk);
      check("r2_done", 32'({busy, valid, result_ch}), 32'b0_0_11);
      alt_mode = 1'b0;

      // Reset in the middle of BIGDIODE on channel 0.
      ch_mask = 4'b0001; cmp_const = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (!PI1 && t < 100) begin @(negedge clk); t++; end
      check("r3_in_big", 32'(PI1), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("r3_busy", 32'({busy, valid, setupBias}), 32'd0);
      check("r3_cmp_p", 32'({cmp_p1, cmp_p2}), 32'b10);
      check("r3_phases", 32'({PI1, PI2, PII1, PII2, preChrg, src_n, snk}), 32'd0);
      check("r3_sel_res", 32'({ch_sel, result, result_ch}), 32'd0);
      repeat (400) @(negedge clk);
      check("r3_no_valid", 32'(n_valid), 32'd3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(4, 1000);
      check("r3_restart_res", 32'(v_res[3]), 32'd16);
      check("r3_restart_lat", 32'(v_cyc[3] - pre_exit_cyc), 32'd288);
      @(negedge clk);

      // Start with an empty mask is ignored.
      ch_mask = 4'b0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("r4_empty", 32'({busy, preChrg, setupBias}), 32'b001);
      repeat (3) @(negedge clk);
      check("r4_idle", 32'({busy, preChrg, ch_sel}), 32'd0);

      // NCYC=2 instance: comparator 0 gives 0, comparator 1 gives full scale 2.
      mask2 = 4'b0001; cmp2 = 1'b0; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      t = 0;
      while (!valid2 && t < 100) begin @(negedge clk); t++; end
      check("n2_latency", 32'(t), 32'd17);
      check("n2_zero", 32'({result2, rch2}), 32'd0);
      @(negedge clk);
      check("n2_busy_drop", 32'(busy2), 32'd0);
      cmp2 = 1'b1; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      t = 0;
      while (!valid2 && t < 100) begin @(negedge clk); t++; end
      check("n2_full", 32'(result2), 32'd2);
      @(negedge clk);

      check("phase_rules", 32'(viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
